cic_comb_decim: RTL and testbench
=================================

CIC_COMB_DECIM -- requirements
Module: cic_comb_decim

Interface
REQ-001 SHALL have parameter IDW, default 23, meaning input width; it matches the upstream integrator output width.
REQ-002 SHALL have parameter ODW, default 16, meaning decimated output width.
REQ-003 SHALL have parameter NS, default 1, meaning number of comb sections (1..3); it equals the number of upstream integrator stages.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the falling edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port os_sel, input, 3 bits: oversampling select, same encoding as the integrator.
REQ-007 SHALL have port data_in, input, IDW bits: two's-complement integrator output, one sample per clk.
REQ-008 SHALL have port data_out, output, ODW bits: decimated, scaled, two's-complement result.
REQ-009 SHALL have port data_valid, output, 1 bit: one-cycle strobe marking a new data_out.
REQ-010 SHALL have port sat, output, 1 bit: asserted with data_valid when the current data_out was saturated.

Function
REQ-011 SHALL decode the decimation ratio R and shift K from os_sel:
- os_sel 001..110: R = 2^os_sel, K = os_sel.
- os_sel 000/111: R = 1, K = 0 (bypass, no decimation).
REQ-012 SHALL run a phase counter 0..R-1 that advances every clk and wraps to 0 after R-1; a decimation tick occurs when the counter equals R-1.
REQ-013 SHALL, on each tick only, sample data_in into comb stage 1.
REQ-014 SHALL compute each comb stage as y = x - x_prev in IDW-bit modular (wrap-around) arithmetic, with differential delay 1 at the decimated rate.
REQ-015 SHALL update x_prev only on ticks.
REQ-016 SHALL form the final comb result arithmetically right-shifted by NS*K bits (floor, no rounding).
REQ-017 SHALL saturate the shifted result to the ODW range [-2^(ODW-1), 2^(ODW-1)-1] and set sat=1 when clipping occurs, else sat=0.
REQ-018 SHALL register data_out, sat and data_valid together, 1 clk after the tick edge; data_valid is high for exactly 1 clk per accepted tick.
REQ-019 SHALL hold data_out and sat between valid strobes.
REQ-020 SHALL register os_sel internally and compare it each clk; on any change it shall:
- reset the phase counter to 0,
- clear all comb delay registers,
- load a warm-up counter with NS.
REQ-021 SHALL, while the warm-up counter is nonzero, decrement it on each tick and suppress data_valid for that tick; data_out and sat keep their last values.
REQ-022 SHALL give the os_sel-change restart priority over a tick that falls in the same clk; no valid strobe is produced in that clk.
REQ-023 SHALL, in bypass (R=1), treat every clk as a tick.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously clear:
- the phase counter and all comb registers,
- the stored os_sel to 000,
- data_out=0, data_valid=0, sat=0.
REQ-025 SHALL, after reset release, load the warm-up counter with NS, so the first NS ticks produce no valid strobe.
REQ-026 SHALL let a reset asserted mid-operation abort any pending output; data_valid shall not pulse on the release edge.

Verification
REQ-027 SHALL cover: os_sel=011, data_in ramp +100 per clk -> data_valid every 8 clk, data_out=100, sat=0 after warm-up.
REQ-028 SHALL cover: same ramp continued across the 2^22 wrap to negative -> data_out stays 100, no glitch.
REQ-029 SHALL cover: os_sel=000, data_in steps of +40000 per clk -> data_valid every clk, data_out=32767, sat=1; steps of -40000 -> data_out=-32768, sat=1.
REQ-030 SHALL cover: os_sel 011->100 mid-stream with ramp +100 -> next tick suppressed, then valid every 16 clk with data_out=100.
REQ-031 SHALL cover: reset_n pulsed low during the cycle before a tick -> no data_valid; outputs 0; first valid after release is NS ticks later.
REQ-032 SHALL cover: os_sel change coinciding with a tick -> no data_valid that clk; counter restarts at 0.

Source files
------------

// File: rtl/cic_comb_decim.sv
// CIC comb and decimator section, clocked on the falling edge.
// Differentiates integrator output at the decimated rate, then scales and saturates it.
module cic_comb_decim #(
    parameter int IDW = 23,
    parameter int ODW = 16,
    parameter int NS  = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [2:0]     os_sel,
    input  logic [IDW-1:0] data_in,
    output logic [ODW-1:0] data_out,
    output logic           data_valid,
    output logic           sat
);

    localparam logic signed [IDW-1:0] MAXV = IDW'(2 ** (ODW - 1) - 1);
    localparam logic signed [IDW-1:0] MINV = -MAXV - IDW'(1);
    localparam logic [4:0]            NSW  = 5'(NS);
    localparam logic [1:0]            WU0  = 2'(NS);

    logic [2:0]     os_q, os_d;
    logic [5:0]     ph_q, ph_d;
    logic [1:0]     wu_q, wu_d;
    logic [IDW-1:0] prev_q [NS];
    logic [IDW-1:0] prev_d [NS];
    logic [ODW-1:0] out_q, out_d;
    logic           vld_q, vld_d;
    logic           sat_q, sat_d;

    logic [2:0]            k;
    logic [5:0]            ph_last;
    logic [4:0]            sh;
    logic                  tick;
    logic                  chg;
    logic [IDW-1:0]        st [NS+1];
    logic signed [IDW-1:0] shf;

    // Decode ratio/shift from the stored oversampling select.
    always_comb begin
        k = os_q;
        if (os_q == 3'd0 || os_q == 3'd7) begin
            k = 3'd0;
        end
        ph_last = (6'd1 << k) - 6'd1;
        sh      = NSW * {2'b00, k};
        tick    = (ph_q == ph_last);
        chg     = (os_sel != os_q);
    end

    // Comb chain: each stage subtracts its value from the previous tick.
    always_comb begin
        st[0] = data_in;
        for (int i = 0; i < NS; i++) begin
            st[i+1] = st[i] - prev_q[i];
        end
        shf = $signed(st[NS]) >>> sh;
    end

    // Next-state: restart on os_sel change, else comb update on ticks.
    always_comb begin
        os_d   = os_sel;
        ph_d   = ph_q + 6'd1;
        wu_d   = wu_q;
        prev_d = prev_q;
        out_d  = out_q;
        sat_d  = sat_q;
        vld_d  = 1'b0;
        if (chg) begin
            ph_d = 6'd0;
            wu_d = WU0;
            for (int i = 0; i < NS; i++) begin
                prev_d[i] = '0;
            end
        end else if (tick) begin
            ph_d = 6'd0;
            for (int i = 0; i < NS; i++) begin
                prev_d[i] = st[i];
            end
            if (wu_q != 2'd0) begin
                wu_d = wu_q - 2'd1;
            end else begin
                vld_d = 1'b1;
                if (shf > MAXV) begin
                    out_d = MAXV[ODW-1:0];
                    sat_d = 1'b1;
                end else if (shf < MINV) begin
                    out_d = MINV[ODW-1:0];
                    sat_d = 1'b1;
                end else begin
                    out_d = shf[ODW-1:0];
                    sat_d = 1'b0;
                end
            end
        end
    end

    // State registers, updated on the falling edge with async clear.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            os_q  <= 3'd0;
            ph_q  <= 6'd0;
            wu_q  <= WU0;
            out_q <= '0;
            vld_q <= 1'b0;
            sat_q <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                prev_q[i] <= '0;
            end
        end else begin
            os_q   <= os_d;
            ph_q   <= ph_d;
            wu_q   <= wu_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
            sat_q  <= sat_d;
            prev_q <= prev_d;
        end
    end

    assign data_out   = out_q;
    assign data_valid = vld_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_cic_comb_decim.sv
// Directed bench for cic_comb_decim (defaults IDW=23, ODW=16, NS=1).
// Inputs change and outputs are sampled on the rising edge, opposite the DUT edge.
module tb_cic_comb_decim;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  os_sel = 3'b011;
    logic [22:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_valid;
    logic        sat;

    int checks = 0;
    int errors = 0;

    int          vq[$];
    logic [15:0] oq[$];
    logic        sq[$];
    logic        last_vld;
    logic [15:0] last_out;
    logic        last_sat;

    always #5 clk = ~clk;

    cic_comb_decim dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .os_sel     (os_sel),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sat        (sat)
    );

    // Release reset on a rising edge; call k of run() then observes falling edge k.
    task automatic do_reset(input logic [2:0] os, input logic [22:0] start);
        @(posedge clk);
        reset_n = 1'b0;
        os_sel  = os;
        data_in = start;
        @(posedge clk);
        reset_n = 1'b1;
    endtask

    // Step n cycles, logging strobes (1-based index within this window).
    task automatic run(input int n, input int step);
        vq.delete();
        oq.delete();
        sq.delete();
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            last_vld = data_valid;
            last_out = data_out;
            last_sat = sat;
            if (data_valid) begin
                vq.push_back(i);
                oq.push_back(data_out);
                sq.push_back(sat);
            end
            data_in = data_in + 23'(step);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (data_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_out: got %0d expected 0", data_out);
        end
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", data_valid);
        end
        checks++;
        if (sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat: got %b expected 0", sat);
        end
    endtask

    // Ramp +100 at R=8, once from 0 and once across the 2^22 sign wrap.
    task automatic test_ramp();
        logic [22:0] starts [2];
        starts[0] = 23'd0;
        starts[1] = 23'd4192304;
        for (int s = 0; s < 2; s++) begin
            do_reset(3'b011, starts[s]);
            run(60, 100);
            checks++;
            if (vq.size() !== 6) begin
                errors++;
                $display("FAIL ramp%0d_count: got %0d expected 6", s, vq.size());
            end
            checks++;
            if (vq.size() == 0 || vq[0] !== 17) begin
                errors++;
                $display("FAIL ramp%0d_first: got %0d expected 17", s,
                         vq.size() == 0 ? -1 : vq[0]);
            end
            for (int i = 1; i < vq.size(); i++) begin
                checks++;
                if (vq[i] - vq[i-1] !== 8) begin
                    errors++;
                    $display("FAIL ramp%0d_gap: got %0d expected 8", s, vq[i] - vq[i-1]);
                end
            end
            for (int i = 0; i < oq.size(); i++) begin
                checks++;
                if (oq[i] !== 16'd100 || sq[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL ramp%0d_val: got %0d sat %b expected 100 sat 0",
                             s, oq[i], sq[i]);
                end
            end
            checks++;
            if (last_vld !== 1'b0 || last_out !== 16'd100) begin
                errors++;
                $display("FAIL ramp%0d_hold: got %0d vld %b expected 100 vld 0",
                         s, last_out, last_vld);
            end
        end
    endtask

    // Bypass: every clk is a tick; large steps saturate both ways.
    task automatic test_bypass();
        do_reset(3'b000, 23'd0);
        run(10, 40000);
        checks++;
        if (vq.size() !== 9 || vq[0] !== 2) begin
            errors++;
            $display("FAIL byp_count: got %0d expected 9", vq.size());
        end
        for (int i = 0; i < oq.size(); i++) begin
            checks++;
            if (oq[i] !== 16'h7fff || sq[i] !== 1'b1) begin
                errors++;
                $display("FAIL byp_pos: got %0d sat %b expected 32767 sat 1", oq[i], sq[i]);
            end
        end
        run(10, -40000);
        checks++;
        if (vq.size() !== 10) begin
            errors++;
            $display("FAIL byp_neg_count: got %0d expected 10", vq.size());
        end
        for (int i = 1; i < oq.size(); i++) begin
            checks++;
            if (oq[i] !== 16'h8000 || sq[i] !== 1'b1) begin
                errors++;
                $display("FAIL byp_neg: got %0d sat %b expected -32768 sat 1",
                         $signed(oq[i]), sq[i]);
            end
        end
    endtask

    // Switch R=8 -> R=16 two clocks before a tick, and exactly on a tick.
    task automatic test_os_change();
        int pre [2];
        pre[0] = 30;
        pre[1] = 24;
        for (int c = 0; c < 2; c++) begin
            do_reset(3'b011, 23'd0);
            run(pre[c], 100);
            os_sel = 3'b100;
            run(70, 100);
            checks++;
            if (vq.size() !== 3) begin
                errors++;
                $display("FAIL osc%0d_count: got %0d expected 3", c, vq.size());
            end
            checks++;
            if (vq.size() == 0 || vq[0] !== 33) begin
                errors++;
                $display("FAIL osc%0d_first: got %0d expected 33", c,
                         vq.size() == 0 ? -1 : vq[0]);
            end
            for (int i = 1; i < vq.size(); i++) begin
                checks++;
                if (vq[i] - vq[i-1] !== 16) begin
                    errors++;
                    $display("FAIL osc%0d_gap: got %0d expected 16", c, vq[i] - vq[i-1]);
                end
            end
            for (int i = 0; i < oq.size(); i++) begin
                checks++;
                if (oq[i] !== 16'd100 || sq[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL osc%0d_val: got %0d expected 100", c, oq[i]);
                end
            end
        end
    endtask

    // Reset pulse in the cycle before a tick aborts it and restarts warm-up.
    task automatic test_reset_mid();
        do_reset(3'b011, 23'd0);
        run(24, 100);
        checks++;
        if (data_out !== 16'd100) begin
            errors++;
            $display("FAIL rmid_pre: got %0d expected 100", data_out);
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if (data_out !== 16'd0 || data_valid !== 1'b0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL rmid_clear: got %0d vld %b sat %b expected 0 0 0",
                     data_out, data_valid, sat);
        end
        reset_n = 1'b1;
        run(40, 100);
        checks++;
        if (vq.size() !== 3) begin
            errors++;
            $display("FAIL rmid_count: got %0d expected 3", vq.size());
        end
        checks++;
        if (vq.size() == 0 || vq[0] !== 17) begin
            errors++;
            $display("FAIL rmid_first: got %0d expected 17", vq.size() == 0 ? -1 : vq[0]);
        end
        for (int i = 0; i < oq.size(); i++) begin
            checks++;
            if (oq[i] !== 16'd100) begin
                errors++;
                $display("FAIL rmid_val: got %0d expected 100", oq[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_bypass();
        test_os_change();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
